// File: rtl/fpu_pkg.sv
// fpu_pkg
// Shared FPU definitions for the fadd scheduler slice.
//   - FLEN / SIGN_BIT : single-precision word layout
//   - FP_ONE / FP_INF / FP_QNAN : handy IEEE-754 constants
//   - MAX_REQ / TAG_W : upper bound on requesters and the tag width that covers it
//   - stage_t         : one pipeline stage record {v, tag, data, ovf}
//   - rr_pick()       : round-robin priority pick (first set bit from a pointer, wrapping)
package fpu_pkg;

   localparam int FLEN     = 32;
   localparam int SIGN_BIT = 31;

   localparam logic [FLEN-1:0] FP_ONE  = 32'h3F80_0000;
   localparam logic [FLEN-1:0] FP_INF  = 32'h7F80_0000;
   localparam logic [FLEN-1:0] FP_QNAN = 32'h7FC0_0000;

   localparam int MAX_REQ = 4;
   localparam int TAG_W   = 2;

   typedef struct packed {
      logic             v;
      logic [TAG_W-1:0] tag;
      logic [FLEN-1:0]  data;
      logic             ovf;
   } stage_t;

   // Returns {found, index}. Scans ptr, ptr+1, ... wrapping at nreq; the
   // descending loop lets the closest candidate to ptr overwrite the others.
   function automatic logic [TAG_W:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                              input logic [TAG_W-1:0]   ptr,
                                              input int                 nreq);
      logic [TAG_W:0]   pick;
      logic [TAG_W-1:0] idx2;
      int               idx;
      pick = '0;
      for (int k = MAX_REQ - 1; k >= 0; k--) begin
         if (k < nreq) begin
            idx = int'(ptr) + k;
            if (idx >= nreq) idx = idx - nreq;
            idx2 = idx[TAG_W-1:0];
            if (valid[idx2]) pick = {1'b1, idx2};
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/fadd.sv
// fadd
// Combinational IEEE-754 single-precision adder, round-to-nearest-even.
// Denormal inputs are treated as zero and tiny results flush to zero.
// Ports:
//   s, t      : operands
//   d         : s + t
//   overflow  : a finite sum rounded past the largest normal (d becomes inf)
//   dbg_swap  : debug, operands were swapped so the larger magnitude leads
module fadd
   import fpu_pkg::*;
(
   input  logic [FLEN-1:0] s,
   input  logic [FLEN-1:0] t,
   output logic [FLEN-1:0] d,
   output logic            overflow,
   output logic            dbg_swap
);

   logic              s_zero, t_zero, s_inf, t_inf, s_nan, t_nan;
   logic              swap, sign;
   logic [FLEN-1:0]   a, b;
   logic [7:0]        ea, ediff;
   logic [23:0]       ma, mb;
   logic [49:0]       shd;
   logic [26:0]       al, r_sub, m27;
   logic [27:0]       r_add;
   logic [4:0]        lz;
   logic signed [9:0] e_res;
   logic              rup;
   logic [24:0]       mr;
   logic [22:0]       frac;

   // Align the smaller operand, add or subtract magnitudes, normalise and
   // round. Mantissas carry three extra bits: guard, round and sticky.
   always_comb begin
      s_zero = (s[30:23] == 8'h00);
      t_zero = (t[30:23] == 8'h00);
      s_inf  = (s[30:23] == 8'hFF) && (s[22:0] == 23'h0);
      t_inf  = (t[30:23] == 8'hFF) && (t[22:0] == 23'h0);
      s_nan  = (s[30:23] == 8'hFF) && (s[22:0] != 23'h0);
      t_nan  = (t[30:23] == 8'hFF) && (t[22:0] != 23'h0);

      swap  = (t[30:0] > s[30:0]);
      a     = swap ? t : s;
      b     = swap ? s : t;
      sign  = a[SIGN_BIT];
      ea    = a[30:23];
      ediff = a[30:23] - b[30:23];
      ma    = {1'b1, a[22:0]};
      mb    = {1'b1, b[22:0]};

      // Anything shifted past the sticky window only contributes a sticky 1.
      shd   = (ediff >= 8'd50) ? '0 : ({mb, 26'b0} >> ediff);
      al    = (ediff >= 8'd50) ? 27'd1 : {shd[49:24], |shd[23:0]};
      r_add = {1'b0, ma, 3'b000} + {1'b0, al};
      r_sub = {ma, 3'b000} - al;

      lz = '0;
      for (int i = 0; i < 27; i++) begin
         if (r_sub[i]) lz = 5'(26 - i);
      end

      m27   = '0;
      e_res = '0;
      if (a[SIGN_BIT] == b[SIGN_BIT]) begin
         if (r_add[27]) begin
            m27   = {r_add[27:2], r_add[1] | r_add[0]};
            e_res = $signed({2'b00, ea}) + 10'sd1;
         end else begin
            m27   = r_add[26:0];
            e_res = $signed({2'b00, ea});
         end
      end else begin
         m27   = r_sub << lz;
         e_res = $signed({2'b00, ea}) - $signed({5'b00000, lz});
      end

      rup = m27[2] & (m27[1] | m27[0] | m27[3]);
      mr  = {1'b0, m27[26:3]} + {24'b0, rup};
      if (mr[24]) begin
         frac  = mr[23:1];
         e_res = e_res + 10'sd1;
      end else begin
         frac  = mr[22:0];
      end

      d        = '0;
      overflow = 1'b0;
      if (s_nan || t_nan || (s_inf && t_inf && (s[SIGN_BIT] != t[SIGN_BIT]))) begin
         d = FP_QNAN;
      end else if (s_inf) begin
         d = s;
      end else if (t_inf) begin
         d = t;
      end else if (s_zero && t_zero) begin
         d = {s[SIGN_BIT] & t[SIGN_BIT], 31'b0};
      end else if (s_zero) begin
         d = t;
      end else if (t_zero) begin
         d = s;
      end else if ((a[SIGN_BIT] != b[SIGN_BIT]) && (r_sub == 27'd0)) begin
         d = '0;
      end else if (e_res >= 10'sd255) begin
         d        = {sign, 8'hFF, 23'b0};
         overflow = 1'b1;
      end else if (e_res <= 10'sd0) begin
         d = {sign, 31'b0};
      end else begin
         d = {sign, e_res[7:0], frac};
      end

      dbg_swap = swap;
   end

endmodule

// File: rtl/fadd_sched.sv
// fadd_sched
// Shares one fadd between NREQ requesters: round-robin grant, fsub turned
// into fadd by flipping the sign of t, fixed LAT-cycle pipeline, and a
// one-cycle one-hot response pulse back to the requester that issued.
// Ports:
//   clk, rstn      : clock, asynchronous active-low reset
//   req_valid      : per-requester request
//   req_ready      : one-hot grant (accepted when valid & ready)
//   req_sub        : 1 = s - t, 0 = s + t
//   req_s, req_t   : operands, requester i in bits [32i+31:32i]
//   flush          : kills every in-flight operation, blocks grants
//   rsp_valid      : one-hot result pulse to the owning requester
//   rsp_data       : result (holds while rsp_valid is 0)
//   rsp_overflow   : fadd overflow flag for rsp_data
//   busy           : some pipeline stage holds a valid operation
module fadd_sched
   import fpu_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int LAT  = 2
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ-1:0]      req_sub,
   input  logic [FLEN*NREQ-1:0] req_s,
   input  logic [FLEN*NREQ-1:0] req_t,
   input  logic                 flush,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [FLEN-1:0]      rsp_data,
   output logic                 rsp_overflow,
   output logic                 busy
);

   logic [TAG_W-1:0]   rr, rr_next, grant;
   logic [TAG_W:0]     pick;
   logic [MAX_REQ-1:0] valid_ext;
   logic               accept;
   logic [FLEN-1:0]    sel_s, sel_t;

   logic               s0_v;
   logic [TAG_W-1:0]   s0_tag;
   logic [FLEN-1:0]    s0_s, s0_t;

   logic [FLEN-1:0]    sum_d;
   logic               sum_ovf;

   stage_t             st [1:LAT-1];

   // Arbitration and operand mux. The sign flip on t is what turns a
   // subtract into an add for the shared datapath.
   always_comb begin
      valid_ext                = '0;
      valid_ext[NREQ-1:0]      = req_valid;
      pick                     = rr_pick(valid_ext, rr, NREQ);
      grant                    = pick[TAG_W-1:0];
      accept                   = pick[TAG_W] & ~flush;
      rr_next                  = (int'(grant) == NREQ - 1) ? '0 : grant + TAG_W'(1);
      req_ready                = '0;
      sel_s                    = '0;
      sel_t                    = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_ready[i] = accept && (grant == TAG_W'(i));
         if (grant == TAG_W'(i)) begin
            sel_s = req_s[FLEN*i +: FLEN];
            sel_t = req_t[FLEN*i +: FLEN];
            sel_t[SIGN_BIT] = req_t[FLEN*i + SIGN_BIT] ^ req_sub[i];
         end
      end
   end

   // Round-robin pointer and issue stage. Operand registers only load on an
   // accepted grant; the valid bit alone says whether S0 is live.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rr     <= '0;
         s0_v   <= 1'b0;
         s0_tag <= '0;
         s0_s   <= '0;
         s0_t   <= '0;
      end else begin
         s0_v <= accept;
         if (accept) begin
            rr     <= rr_next;
            s0_tag <= grant;
            s0_s   <= sel_s;
            s0_t   <= sel_t;
         end
      end
   end

   fadd u_fadd (
      .s        (s0_s),
      .t        (s0_t),
      .d        (sum_d),
      .overflow (sum_ovf),
      .dbg_swap ()
   );

   // Compute and delay stages. Data only moves with a surviving valid so the
   // final stage, and therefore rsp_data, holds between responses.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int j = 1; j < LAT; j++) st[j] <= '0;
      end else begin
         st[1].v <= s0_v & ~flush;
         if (s0_v && !flush) begin
            st[1].tag  <= s0_tag;
            st[1].data <= sum_d;
            st[1].ovf  <= sum_ovf;
         end
         for (int j = 2; j < LAT; j++) begin
            st[j].v <= st[j-1].v & ~flush;
            if (st[j-1].v && !flush) begin
               st[j].tag  <= st[j-1].tag;
               st[j].data <= st[j-1].data;
               st[j].ovf  <= st[j-1].ovf;
            end
         end
      end
   end

   // Response decode from the last stage, plus the occupancy flag.
   always_comb begin
      rsp_data     = st[LAT-1].data;
      rsp_overflow = st[LAT-1].ovf;
      rsp_valid    = '0;
      for (int i = 0; i < NREQ; i++) begin
         rsp_valid[i] = st[LAT-1].v && (st[LAT-1].tag == TAG_W'(i));
      end
      busy = s0_v;
      for (int j = 1; j < LAT; j++) busy = busy | st[j].v;
   end

endmodule

// File: doc/fadd_sched.md
Name: fadd_sched

Overview:
- Time-shares a single fadd datapath instance between NREQ requesters, e.g. the FPU issue port and the FP-compare/convert helper.
- Does round-robin arbitration and fsub-to-fadd sign flipping, wraps the combinational adder in a fixed-latency pipeline, and returns each result to its originating requester with a one-cycle response pulse.
- Sits between the core's FP execute stage and the fadd instance.

Parameters:
- NREQ, 2, number of requesters (2..4).
- LAT, 2, issue-to-response latency in cycles (2..4). Beyond the 2 mandatory stages there are LAT-2 extra delay stages.

Ports:
- clk  input  1  core clock.
- rstn  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester operation request.
- req_ready  output  NREQ  one-hot grant; the request is accepted when valid&ready.
- req_sub  input  NREQ  1 = s - t, 0 = s + t.
- req_s  input  32*NREQ  operand s. Requester i occupies bits [32i+31:32i].
- req_t  input  32*NREQ  operand t, same packing as req_s.
- flush  input  1  synchronous kill of all in-flight operations.
- rsp_valid  output  NREQ  one-hot, one-cycle result pulse to the owning requester.
- rsp_data  output  32  IEEE-754 single result.
- rsp_overflow  output  1  fadd overflow flag for the result.
- busy  output  1  any pipeline stage holds a valid operation.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rstn).
- Reset values:
  - rsp_valid=0, rsp_data=0, rsp_overflow=0, busy=0.
  - Round-robin pointer rr=0.
  - All stage valid bits = 0 and stage data regs = 0.
- Arbitration (combinational):
  - req_ready grants the first asserted req_valid[i] searching from index rr upward, wrapping modulo NREQ.
  - At most one bit of req_ready is set per cycle.
  - req_ready=0 everywhere when flush=1.
  - req_ready may depend on req_valid in the same cycle; requesters must not make valid depend on ready.
- Pointer update:
  - On an accepted grant to index g, rr <= (g+1) mod NREQ.
  - With no grant, rr holds.
  - Every continuously requesting index is granted within NREQ cycles.
- Issue stage S0, registered on the edge ending acceptance cycle k:
  - s0_s <= req_s[g].
  - s0_t <= req_t[g] with bit 31 inverted when req_sub[g]=1.
  - s0_tag <= g, s0_v <= 1.
  - The pipeline never stalls, so a new issue is accepted every cycle.
- Compute stage S1: the fadd sub-instance is combinational on s0_s and s0_t. Its d and overflow outputs are registered with s0_tag and s0_v on the next edge.
- Delay stages S2..S(LAT-1): plain shift registers of {v, tag, data, overflow}.
- Response timing:
  - The final stage drives rsp_data and rsp_overflow.
  - rsp_valid is the one-hot of the stage tag, gated by the stage valid.
  - A request accepted in cycle k responds in cycle k+LAT exactly.
  - rsp_data and rsp_overflow hold their last value while rsp_valid=0.
- Ordering: responses are in issue order both globally and per requester. There is no backpressure, so requesters must sink a response in the cycle it arrives.
- flush=1 in cycle k:
  - All stage valid bits are cleared at the edge ending k, and no grant is given in k.
  - No rsp_valid is produced for anything issued at or before k.
  - The response already visible in cycle k is still delivered.
  - Data registers need not be cleared.
- busy = OR of all stage valid bits, including the output stage.
- Reset mid-operation: in-flight work is discarded and no response pulses are produced after rstn rises.
- Special operands (NaN, inf, zero, denormal shortcut) are handled entirely by fadd; this block does not inspect operands other than the sign flip.

Decomposition:
- Shared package fpu_pkg:
  - FLEN=32 and the sign bit index 31.
  - Constants FP_ONE=32'h3F800000 and FP_INF=32'h7F800000 for benches.
  - A round-robin priority helper function (first set bit from pointer, wrapping).
- One sub-module: the existing fadd, instantiated once. Its debug outputs are left unconnected.
- Arbiter, stage registers and tag decode live inline in fadd_sched. There is no separate arbiter module.

Test Plan:
- Single add: NREQ=2, LAT=2. Req0 s=3F800000 t=40000000 sub=0 accepted in cycle 5 -> rsp_valid=01 in cycle 7, rsp_data=40400000, rsp_overflow=0.
- Subtract: req1 s=3F800000 t=3F800000 sub=1 -> rsp_valid=10 after LAT cycles, rsp_data=00000000. Also s=40400000 t=3F800000 sub=1 -> 40000000.
- Round-robin: both valid every cycle from reset, distinct operands -> grants 0,1,0,1,…, back-to-back responses with alternating rsp_valid, each carrying its own sum, no cycle lost.
- Overflow: s=t=7F7FFFFF add -> rsp_data=7F800000, rsp_overflow=1. Special case: 7F800000 + FF800000 -> 7FC00000.
- Flush: issue 3 consecutive ops (cycles 10–12), flush in cycle 12 -> only the op issued in cycle 10 responds (cycle 12), none after, req_ready=0 in cycle 12, busy=0 from cycle 13.
- Reset: assert rstn=0 asynchronously mid-pipeline with two ops in flight -> all outputs 0 immediately, rr=0, no rsp_valid after release. LAT=4 build repeats the single-add test with a response at k+4.
